// File: rtl/riscv_pkg.sv
// Shared widths, ALU opcodes and forwarding-select encoding for the core.
package riscv_pkg;

  localparam int RV_DATA_WIDTH     = 32;
  localparam int RV_ALUCTRL_WIDTH  = 4;
  localparam int RV_REG_ADDR_WIDTH = 5;

  // ALU opcodes, encoded as {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/forward_mux.sv
// Priority forwarding for one source operand: EX/MEM beats MEM/WB beats the
// register-file value; x0 is never forwarded.
module forward_mux
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = RV_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = RV_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     src_data,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output fwd_sel_t                  fwd_sel,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  // Pick the youngest producer of src_addr, ignoring writes to x0
  always_comb begin
    fwd_sel = FWD_REG;
    if (exmem_reg_write && (exmem_rd != {REG_ADDR_WIDTH{1'b0}}) && (exmem_rd == src_addr)) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != {REG_ADDR_WIDTH{1'b0}}) && (memwb_rd == src_addr)) begin
      fwd_sel = FWD_MEMWB;
    end else begin
      fwd_sel = FWD_REG;
    end
  end

  // Steer the selected value onto the operand bus
  always_comb begin
    fwd_data = src_data;
    case (fwd_sel)
      FWD_EXMEM: fwd_data = exmem_result;
      FWD_MEMWB: fwd_data = memwb_result;
      FWD_REG:   fwd_data = src_data;
      default:   fwd_data = src_data;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion and operand
// forwarding; feeds the ALU and the downstream control/store-data fields.
module ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = RV_DATA_WIDTH,
  parameter int ALUCTRL_WIDTH  = RV_ALUCTRL_WIDTH,
  parameter int REG_ADDR_WIDTH = RV_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [ALUCTRL_WIDTH-1:0]  id_alu_ctrl,
  input  logic                      id_alusrc_pc,
  input  logic                      id_alusrc_imm,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      exmem_reg_write,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [ALUCTRL_WIDTH-1:0]  ALUCtrl,
  output logic [DATA_WIDTH-1:0]     ALUop1,
  output logic [DATA_WIDTH-1:0]     ALUop2,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      id_hold,
  output logic [31:0]               stall_count
);

  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     pc_q, pc_d;
  logic [DATA_WIDTH-1:0]     imm_q, imm_d;
  logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0]     rs2_data_q, rs2_data_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ALUCTRL_WIDTH-1:0]  alu_ctrl_q, alu_ctrl_d;
  logic                      alusrc_pc_q, alusrc_pc_d;
  logic                      alusrc_imm_q, alusrc_imm_d;
  logic                      reg_write_q, reg_write_d;
  logic                      mem_read_q, mem_read_d;
  logic                      mem_write_q, mem_write_d;
  logic [31:0]               stall_count_q, stall_count_d;

  logic                      load_use_s;
  logic                      id_hold_s;
  logic [DATA_WIDTH-1:0]     fwd_rs1_s;
  logic [DATA_WIDTH-1:0]     fwd_rs2_s;
  fwd_sel_t                  rs1_sel_s;
  fwd_sel_t                  rs2_sel_s;
  logic                      unused_fwd_sel_s;

  // Load in EX whose result a decoding instruction actually reads: one bubble
  always_comb begin
    load_use_s = valid_q && mem_read_q && (rd_addr_q != {REG_ADDR_WIDTH{1'b0}}) && id_valid &&
                 ((id_uses_rs1 && (id_rs1_addr == rd_addr_q)) ||
                  (id_uses_rs2 && (id_rs2_addr == rd_addr_q)));
    id_hold_s  = (load_use_s || stall) && !flush;
  end

  // Next-state selection: flush > stall > load-use bubble > normal load
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rd_addr_d    = rd_addr_q;
    alu_ctrl_d   = alu_ctrl_q;
    alusrc_pc_d  = alusrc_pc_q;
    alusrc_imm_d = alusrc_imm_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    if (flush || (!stall && load_use_s)) begin
      valid_d      = 1'b0;
      pc_d         = {DATA_WIDTH{1'b0}};
      imm_d        = {DATA_WIDTH{1'b0}};
      rs1_data_d   = {DATA_WIDTH{1'b0}};
      rs2_data_d   = {DATA_WIDTH{1'b0}};
      rs1_addr_d   = {REG_ADDR_WIDTH{1'b0}};
      rs2_addr_d   = {REG_ADDR_WIDTH{1'b0}};
      rd_addr_d    = {REG_ADDR_WIDTH{1'b0}};
      alu_ctrl_d   = {ALUCTRL_WIDTH{1'b0}};
      alusrc_pc_d  = 1'b0;
      alusrc_imm_d = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d      = id_valid;
      pc_d         = id_pc;
      imm_d        = id_imm;
      rs1_data_d   = id_rs1_data;
      rs2_data_d   = id_rs2_data;
      rs1_addr_d   = id_rs1_addr;
      rs2_addr_d   = id_rs2_addr;
      rd_addr_d    = id_rd_addr;
      alu_ctrl_d   = id_alu_ctrl;
      alusrc_pc_d  = id_alusrc_pc;
      alusrc_imm_d = id_alusrc_imm;
      reg_write_d  = id_reg_write && id_valid;
      mem_read_d   = id_mem_read && id_valid;
      mem_write_d  = id_mem_write && id_valid;
    end
  end

  // Saturating count of cycles in which decode is held
  always_comb begin
    if (id_hold_s && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Pipeline and counter registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      pc_q          <= {DATA_WIDTH{1'b0}};
      imm_q         <= {DATA_WIDTH{1'b0}};
      rs1_data_q    <= {DATA_WIDTH{1'b0}};
      rs2_data_q    <= {DATA_WIDTH{1'b0}};
      rs1_addr_q    <= {REG_ADDR_WIDTH{1'b0}};
      rs2_addr_q    <= {REG_ADDR_WIDTH{1'b0}};
      rd_addr_q     <= {REG_ADDR_WIDTH{1'b0}};
      alu_ctrl_q    <= {ALUCTRL_WIDTH{1'b0}};
      alusrc_pc_q   <= 1'b0;
      alusrc_imm_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      stall_count_q <= 32'd0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_addr_q     <= rd_addr_d;
      alu_ctrl_q    <= alu_ctrl_d;
      alusrc_pc_q   <= alusrc_pc_d;
      alusrc_imm_q  <= alusrc_imm_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      stall_count_q <= stall_count_d;
    end
  end

  forward_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .src_addr        (rs1_addr_q),
    .src_data        (rs1_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_sel         (rs1_sel_s),
    .fwd_data        (fwd_rs1_s)
  );

  forward_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .src_addr        (rs2_addr_q),
    .src_data        (rs2_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_sel         (rs2_sel_s),
    .fwd_data        (fwd_rs2_s)
  );

  // Forward selects are debug-visible only; the data path uses the muxed value
  always_comb begin
    unused_fwd_sel_s = ^{rs1_sel_s, rs2_sel_s};
  end

  // ALU operand select and pass-through of EX-stage fields
  always_comb begin
    ALUCtrl       = alu_ctrl_q;
    ALUop1        = alusrc_pc_q  ? pc_q  : fwd_rs1_s;
    ALUop2        = alusrc_imm_q ? imm_q : fwd_rs2_s;
    ex_store_data = fwd_rs2_s;
    ex_valid      = valid_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
    ex_rd_addr    = rd_addr_q;
    id_hold       = id_hold_s;
    stall_count   = stall_count_q;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed and randomized checks of ex_operand_stage against a behavioural model.
module tb_ex_operand_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_alusrc_pc, id_alusrc_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, stall, flush;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [3:0]  ALUCtrl;
  logic [31:0] ALUop1, ALUop2, ex_store_data, stall_count;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_hold;
  logic [4:0]  ex_rd_addr;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_alu_ctrl(id_alu_ctrl),
    .id_alusrc_pc(id_alusrc_pc), .id_alusrc_imm(id_alusrc_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .ALUCtrl(ALUCtrl), .ALUop1(ALUop1), .ALUop2(ALUop2),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd_addr(ex_rd_addr), .ex_store_data(ex_store_data),
    .id_hold(id_hold), .stall_count(stall_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the instruction currently sitting in EX
  logic        m_valid, m_rw, m_mr, m_mw, m_srcpc, m_srcimm;
  logic [31:0] m_pc, m_imm, m_rs1d, m_rs2d;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [3:0]  m_ctrl;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] d);
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  function automatic logic m_load_use();
    return m_valid && m_mr && (m_rd != 5'd0) && id_valid &&
           ((id_uses_rs1 && id_rs1_addr == m_rd) || (id_uses_rs2 && id_rs2_addr == m_rd));
  endfunction

  function automatic logic m_hold();
    return (m_load_use() || stall) && !flush;
  endfunction

  task automatic model_clear();
    {m_valid, m_rw, m_mr, m_mw, m_srcpc, m_srcimm} = 6'd0;
    {m_pc, m_imm, m_rs1d, m_rs2d} = 128'd0;
    {m_rs1a, m_rs2a, m_rd} = 15'd0;
    m_ctrl = 4'd0;
    m_cnt  = 32'd0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":ALUop1"}, ALUop1, m_srcpc ? m_pc : m_fwd(m_rs1a, m_rs1d));
    chk({ph, ":ALUop2"}, ALUop2, m_srcimm ? m_imm : m_fwd(m_rs2a, m_rs2d));
    chk({ph, ":store"}, ex_store_data, m_fwd(m_rs2a, m_rs2d));
    chk({ph, ":ALUCtrl"}, ALUCtrl, m_ctrl);
    chk({ph, ":ex_valid"}, ex_valid, m_valid);
    chk({ph, ":ex_reg_write"}, ex_reg_write, m_rw);
    chk({ph, ":ex_mem_read"}, ex_mem_read, m_mr);
    chk({ph, ":ex_mem_write"}, ex_mem_write, m_mw);
    chk({ph, ":ex_rd_addr"}, ex_rd_addr, m_rd);
    chk({ph, ":id_hold"}, id_hold, m_hold());
    chk({ph, ":stall_count"}, stall_count, m_cnt);
  endtask

  // One clock: check before the edge, advance the model, check after the edge
  task automatic step();
    logic h, lu;
    #1;
    check_all("pre");
    h  = m_hold();
    lu = m_load_use();
    @(posedge clk);
    if (h && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (flush || (!stall && lu)) begin
      logic [31:0] keep;
      keep = m_cnt;
      model_clear();
      m_cnt = keep;
    end else if (!stall) begin
      m_valid = id_valid;      m_rw = id_reg_write & id_valid;
      m_mr = id_mem_read & id_valid;  m_mw = id_mem_write & id_valid;
      m_srcpc = id_alusrc_pc;  m_srcimm = id_alusrc_imm;
      m_pc = id_pc;  m_imm = id_imm;  m_rs1d = id_rs1_data;  m_rs2d = id_rs2_data;
      m_rs1a = id_rs1_addr;  m_rs2a = id_rs2_addr;  m_rd = id_rd_addr;  m_ctrl = id_alu_ctrl;
    end
    #1;
    check_all("post");
    @(negedge clk);
  endtask

  task automatic set_idle();
    {id_valid, id_uses_rs1, id_uses_rs2, id_alusrc_pc, id_alusrc_imm} = 5'd0;
    {id_reg_write, id_mem_read, id_mem_write, stall, flush} = 5'd0;
    {id_pc, id_imm, id_rs1_data, id_rs2_data} = 128'd0;
    {id_rs1_addr, id_rs2_addr, id_rd_addr} = 15'd0;
    id_alu_ctrl = 4'd0;
    {exmem_reg_write, memwb_reg_write} = 2'd0;
    {exmem_rd, memwb_rd} = 10'd0;
    {exmem_result, memwb_result} = 64'd0;
  endtask

  task automatic rand_inputs();
    id_valid = ($urandom_range(0, 3) != 0);
    id_pc = $urandom;  id_imm = $urandom;  id_rs1_data = $urandom;  id_rs2_data = $urandom;
    id_rs1_addr = 5'($urandom_range(0, 7));
    id_rs2_addr = 5'($urandom_range(0, 7));
    id_rd_addr  = 5'($urandom_range(0, 7));
    id_uses_rs1 = 1'($urandom);  id_uses_rs2 = 1'($urandom);
    id_alu_ctrl = 4'($urandom);
    id_alusrc_pc = 1'($urandom);  id_alusrc_imm = 1'($urandom);
    id_reg_write = 1'($urandom);  id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom);
    stall = ($urandom_range(0, 9) == 0);
    flush = ($urandom_range(0, 14) == 0);
    exmem_reg_write = 1'($urandom);  memwb_reg_write = 1'($urandom);
    exmem_rd = 5'($urandom_range(0, 7));  memwb_rd = 5'($urandom_range(0, 7));
    exmem_result = $urandom;  memwb_result = $urandom;
  endtask

  initial begin
    set_idle();
    model_clear();
    rst = 1'b1;
    #1;
    chk("reset:ALUop1", ALUop1, 64'd0);
    chk("reset:ALUop2", ALUop2, 64'd0);
    chk("reset:ALUCtrl", ALUCtrl, 64'd0);
    chk("reset:id_hold", id_hold, 64'd0);
    chk("reset:stall_count", stall_count, 64'd0);
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Some arbitrary traffic, then reset asserted between edges
    rand_inputs();  stall = 1'b0;  flush = 1'b0;  id_valid = 1'b1;
    step();
    #2;
    rst = 1'b1;
    set_idle();
    #1;
    model_clear();
    chk("midrst:ex_valid", ex_valid, 64'd0);
    chk("midrst:ALUop1", ALUop1, 64'd0);
    chk("midrst:ALUop2", ALUop2, 64'd0);
    check_all("midrst");
    id_valid = 1'b1;  id_rs1_data = 32'd5;  id_imm = 32'd7;  id_alusrc_imm = 1'b1;
    id_alu_ctrl = ALU_ADD;  id_rs1_addr = 5'd1;  id_rd_addr = 5'd2;  id_reg_write = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("load:ALUop1", ALUop1, 64'd5);
    chk("load:ALUop2", ALUop2, 64'd7);
    chk("load:ex_valid", ex_valid, 64'd1);

    // Forwarding priority
    set_idle();
    id_valid = 1'b1;  id_rs1_addr = 5'd3;  id_rs1_data = 32'h11;
    step();
    exmem_reg_write = 1'b1;  memwb_reg_write = 1'b1;
    exmem_rd = 5'd3;  memwb_rd = 5'd3;
    exmem_result = 32'hAA;  memwb_result = 32'hBB;
    #1;
    chk("fwd:exmem_wins", ALUop1, 64'hAA);
    exmem_rd = 5'd0;
    #1;
    chk("fwd:x0_not_fwd", ALUop1, 64'hBB);

    // Load-use: lw x4 in EX, add x5,x4,x1 in ID
    set_idle();
    id_valid = 1'b1;  id_mem_read = 1'b1;  id_reg_write = 1'b1;  id_rd_addr = 5'd4;
    id_rs1_addr = 5'd2;  id_uses_rs1 = 1'b1;
    step();
    set_idle();
    id_valid = 1'b1;  id_rs1_addr = 5'd4;  id_uses_rs1 = 1'b1;  id_rs2_addr = 5'd1;
    id_uses_rs2 = 1'b1;  id_rd_addr = 5'd5;  id_reg_write = 1'b1;
    #1;
    chk("lu:hold", id_hold, 64'd1);
    step();
    chk("lu:bubble", ex_valid, 64'd0);
    chk("lu:hold_drop", id_hold, 64'd0);
    step();
    chk("lu:add_valid", ex_valid, 64'd1);
    chk("lu:add_rd", ex_rd_addr, 64'd5);
    chk("lu:stall_count", stall_count, 64'd1);

    // No false hazard: lw to x0, then unused rs2 match
    set_idle();
    id_valid = 1'b1;  id_mem_read = 1'b1;  id_reg_write = 1'b1;  id_rd_addr = 5'd0;
    step();
    set_idle();
    id_valid = 1'b1;  id_rs1_addr = 5'd0;  id_uses_rs1 = 1'b1;
    #1;
    chk("nohz:x0", id_hold, 64'd0);
    step();
    set_idle();
    id_valid = 1'b1;  id_mem_read = 1'b1;  id_reg_write = 1'b1;  id_rd_addr = 5'd6;
    step();
    set_idle();
    id_valid = 1'b1;  id_rs2_addr = 5'd6;  id_uses_rs2 = 1'b0;
    id_rs1_addr = 5'd2;  id_uses_rs1 = 1'b1;
    #1;
    chk("nohz:rs2_unused", id_hold, 64'd0);
    step();

    // Flush together with stall
    set_idle();
    id_valid = 1'b1;  id_mem_write = 1'b1;  stall = 1'b1;  flush = 1'b1;
    #1;
    chk("flush:hold", id_hold, 64'd0);
    step();
    chk("flush:ex_valid", ex_valid, 64'd0);
    chk("flush:ex_mem_write", ex_mem_write, 64'd0);
    chk("flush:stall_count", stall_count, 64'd1);

    // Store data forwarded from MEM/WB while ALUop2 takes the immediate
    set_idle();
    id_valid = 1'b1;  id_mem_write = 1'b1;  id_rs2_addr = 5'd7;  id_uses_rs2 = 1'b1;
    id_rs1_addr = 5'd1;  id_uses_rs1 = 1'b1;  id_alusrc_imm = 1'b1;  id_imm = 32'h10;
    step();
    memwb_reg_write = 1'b1;  memwb_rd = 5'd7;  memwb_result = 32'h1234;
    #1;
    chk("sw:ALUop2", ALUop2, 64'h10);
    chk("sw:store_data", ex_store_data, 64'h1234);

    // Reset while stalled, then first edge loads normally
    set_idle();
    stall = 1'b1;
    step();
    #2;
    rst = 1'b1;
    stall = 1'b0;
    #1;
    model_clear();
    chk("rststall:ex_valid", ex_valid, 64'd0);
    chk("rststall:stall_count", stall_count, 64'd0);
    id_valid = 1'b1;  id_rs1_data = 32'd9;  id_rd_addr = 5'd3;  id_reg_write = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rststall:load_valid", ex_valid, 64'd1);
    chk("rststall:load_rd", ex_rd_addr, 64'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
